// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the shared right-shifter arbiter.
// The shifter is fixed at 32 bits, so the datapath widths live here rather than as parameters.
package shift_arbiter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        logic               arith;
    } shift_req_t;

    typedef enum logic {
        ReqId0 = 1'b0,
        ReqId1 = 1'b1
    } req_id_e;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// On a tie, the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o,
    output logic       grant_valid_o
);

    always_comb begin
        grant_id_o    = valid_i[1] & (~valid_i[0] | ~last_grant_i);
        grant_valid_o = |valid_i;
        grant_o[0]    = valid_i[0] & ~grant_id_o;
        grant_o[1]    = valid_i[1] & grant_id_o;
    end

endmodule

// File: rtl/shift_right.sv
// 32-bit right shifter.
// select_bit_i=1 fills with zeros; select_bit_i=0 fills with data_i[31].
module shift_right (
    input  logic [31:0] data_i,
    input  logic [4:0]  shamt_i,
    input  logic        select_bit_i,
    output logic [31:0] data_o
);

    logic        fill;
    logic [31:0] fill_mask;

    always_comb begin
        fill      = select_bit_i ? 1'b0 : data_i[31];
        fill_mask = ~(32'hFFFF_FFFF >> shamt_i);
        data_o    = (data_i >> shamt_i) | ({32{fill}} & fill_mask);
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one right shifter between two requesters through round-robin arbitration.
// Results go through a single registered response slot; each requester has a saturating accept counter.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic [SHAMT_W-1:0]  req0_shamt,
    input  logic                req0_arith,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_data,
    input  logic [SHAMT_W-1:0]  req1_shamt,
    input  logic                req1_arith,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_id,

    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    acc_cnt0,
    output logic [CNT_W-1:0]    acc_cnt1
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    slot_state_e        state_q, state_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic [1:0]         grant;
    logic               grant_id;
    logic               grant_valid;
    logic               slot_free;
    logic               accept;
    shift_req_t         req0_pl, req1_pl, sel_pl;
    logic [DATA_W-1:0]  shift_res;

    rr_arb2 u_arb (
        .valid_i       ({req1_valid, req0_valid}),
        .last_grant_i  (last_grant_q),
        .grant_o       (grant),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        req0_pl = '{data: req0_data, shamt: req0_shamt, arith: req0_arith};
        req1_pl = '{data: req1_data, shamt: req1_shamt, arith: req1_arith};
        sel_pl  = (grant_id == ReqId1) ? req1_pl : req0_pl;
    end

    shift_right u_shift (
        .data_i       (sel_pl.data),
        .shamt_i      (sel_pl.shamt),
        .select_bit_i (~sel_pl.arith),
        .data_o       (shift_res)
    );

    // Nothing is accepted while reset is held, so the slot can never fill during reset.
    always_comb begin
        slot_free  = rst_n & ((state_q == SlotEmpty) | rsp_ready);
        accept     = slot_free & grant_valid;
        req0_ready = slot_free & grant[0];
        req1_ready = slot_free & grant[1];
    end

    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        unique case (state_q)
            SlotEmpty: begin
                if (accept) begin
                    state_d = SlotFull;
                end
            end
            SlotFull: begin
                if (rsp_ready && !accept) begin
                    state_d = SlotEmpty;
                end
            end
            default: state_d = SlotEmpty;
        endcase

        if (accept) begin
            rsp_data_d   = shift_res;
            rsp_id_d     = grant_id;
            last_grant_d = grant_id;
        end

        if (clr_cnt) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (accept) begin
            if (grant_id == ReqId0 && cnt0_q != CntMax) begin
                cnt0_d = cnt0_q + 1'b1;
            end
            if (grant_id == ReqId1 && cnt1_q != CntMax) begin
                cnt1_d = cnt1_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SlotEmpty;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    always_comb begin
        rsp_valid = (state_q == SlotFull);
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
        acc_cnt0  = cnt0_q;
        acc_cnt1  = cnt1_q;
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter, built with 4-bit counters so that saturation is reachable.
module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_arith;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_ready, req1_arith;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic        clr_cnt;
    logic [3:0]  acc_cnt0, acc_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    shift_arbiter #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_arith (req0_arith),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_arith (req1_arith),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .clr_cnt    (clr_cnt),
        .acc_cnt0   (acc_cnt0),
        .acc_cnt1   (acc_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] golden(input logic [31:0] d, input logic [4:0] s, input logic a);
        if (a) return $unsigned($signed(d) >>> s);
        return d >> s;
    endfunction

    // Requester rule: a pending request must keep valid and payload stable until taken.
    logic        pend0, pend1;
    logic [38:0] hold0, hold1;
    initial begin
        pend0 = 1'b0;
        pend1 = 1'b0;
    end
    always @(posedge clk) begin
        if (pend0 && rst_n) check_eq("req0_stable", {req0_valid, req0_data, req0_shamt, req0_arith}, hold0);
        if (pend1 && rst_n) check_eq("req1_stable", {req1_valid, req1_data, req1_shamt, req1_arith}, hold1);
        pend0 <= rst_n & req0_valid & ~req0_ready;
        pend1 <= rst_n & req1_valid & ~req1_ready;
        hold0 <= {req0_valid, req0_data, req0_shamt, req0_arith};
        hold1 <= {req1_valid, req1_data, req1_shamt, req1_arith};
    end

    task automatic issue1(input logic [31:0] d, input logic [4:0] s, input logic a);
        req1_data  = d;
        req1_shamt = s;
        req1_arith = a;
        req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        clr_cnt    = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 32'h8000_0000;
        req0_shamt = 5'd4;
        req0_arith = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 32'h0000_0001;
        req1_shamt = 5'd0;
        req1_arith = 1'b0;

        // Reset held two cycles with both requesters asserting
        tick();
        check_eq("rst_ready0", req0_ready, 0);
        check_eq("rst_ready1", req1_ready, 0);
        tick();
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_data", rsp_data, 0);
        check_eq("rst_id", rsp_id, 0);
        check_eq("rst_cnt0", acc_cnt0, 0);
        check_eq("rst_cnt1", acc_cnt1, 0);
        check_eq("rst_ready0_b", req0_ready, 0);

        rst_n = 1'b1;
        #1;
        check_eq("first_ready0", req0_ready, 1);
        check_eq("first_ready1", req1_ready, 0);
        tick();
        check_eq("arith_valid", rsp_valid, 1);
        check_eq("arith_data", rsp_data, 32'hF800_0000);
        check_eq("arith_id", rsp_id, 0);
        req0_valid = 1'b0;
        tick();
        check_eq("req1_data", rsp_data, 32'h0000_0001);
        check_eq("req1_id", rsp_id, 1);
        req1_valid = 1'b0;
        req0_arith = 1'b0;
        req0_valid = 1'b1;
        tick();
        check_eq("logic_data", rsp_data, 32'h0800_0000);
        check_eq("logic_id", rsp_id, 0);
        req0_valid = 1'b0;
        tick();
        check_eq("drain_valid", rsp_valid, 0);
        check_eq("cnt0_a", acc_cnt0, 2);
        check_eq("cnt1_a", acc_cnt1, 1);

        // Shift corners
        req0_data  = 32'h1234_5678;
        req0_shamt = 5'd0;
        req0_arith = 1'b1;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check_eq("shamt0", rsp_data, 32'h1234_5678);
        req0_data  = 32'hFFFF_FFFE;
        req0_shamt = 5'd31;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check_eq("shamt31_arith", rsp_data, 32'hFFFF_FFFF);
        issue1(32'hFFFF_FFFE, 5'd31, 1'b0);
        check_eq("shamt31_logic", rsp_data, 32'h0000_0001);
        check_eq("shamt31_id", rsp_id, 1);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check_eq("clr_cnt0", acc_cnt0, 0);
        check_eq("clr_cnt1", acc_cnt1, 0);

        // Both requesters streaming: ids alternate starting with 0
        req0_data  = 32'hA5A5_0000;
        req0_shamt = 5'd8;
        req0_arith = 1'b1;
        req1_data  = 32'h0F0F_F0F0;
        req1_shamt = 5'd4;
        req1_arith = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq("alt_valid", rsp_valid, 1);
            check_eq("alt_id", rsp_id, i % 2);
            check_eq("alt_data", rsp_data, (i % 2 == 0) ? 32'hFFA5_A500 : 32'h00F0_FF0F);
            if (i == 7) req1_valid = 1'b0;
            if (i == 8) req0_valid = 1'b0;
        end
        check_eq("alt_cnt0", acc_cnt0, 5);
        check_eq("alt_cnt1", acc_cnt1, 4);
        tick();
        check_eq("alt_drain", rsp_valid, 0);

        // Backpressure: last grant was 0, so req1 wins the tie
        rsp_ready  = 1'b0;
        req0_data  = 32'h8000_0001;
        req0_shamt = 5'd1;
        req0_arith = 1'b1;
        req1_data  = 32'h7654_3210;
        req1_shamt = 5'd16;
        req1_arith = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("bp_ready1", req1_ready, 1);
        check_eq("bp_ready0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_hold_r0", req0_ready, 0);
            check_eq("bp_hold_r1", req1_ready, 0);
            check_eq("bp_hold_valid", rsp_valid, 1);
            check_eq("bp_hold_data", rsp_data, 32'h0000_7654);
            check_eq("bp_hold_id", rsp_id, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_refill_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check_eq("bp_refill_valid", rsp_valid, 1);
        check_eq("bp_refill_data", rsp_data, 32'hC000_0000);
        check_eq("bp_refill_id", rsp_id, 0);
        check_eq("bp_cnt0", acc_cnt0, 6);
        check_eq("bp_cnt1", acc_cnt1, 5);
        tick();
        check_eq("bp_empty", rsp_valid, 0);

        // Random golden comparison at byte-multiple shift amounts
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] d;
            logic [4:0]  s;
            logic        a;
            d = $urandom;
            s = 5'(8 * (1 + (i % 3)));
            a = 1'((i / 3) % 2);
            issue1(d, s, a);
            check_eq("rand_shift", rsp_data, golden(d, s, a));
        end

        // Counter saturation at 15 for the 4-bit build
        req0_data  = 32'h0000_00FF;
        req0_shamt = 5'd0;
        req0_arith = 1'b0;
        clr_cnt    = 1'b1;
        tick();
        clr_cnt    = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_cnt0", acc_cnt0, 15);
        check_eq("sat_data", rsp_data, 32'h0000_00FF);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check_eq("clr_accept_cnt0", acc_cnt0, 0);
        check_eq("clr_accept_valid", rsp_valid, 1);
        tick();
        check_eq("post_clr_cnt0", acc_cnt0, 1);

        // Reset while the slot is full and stalled
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        tick();
        check_eq("stall_full", rsp_valid, 1);
        req0_valid = 1'b1;
        rst_n      = 1'b0;
        tick();
        check_eq("mid_rst_valid", rsp_valid, 0);
        check_eq("mid_rst_data", rsp_data, 0);
        check_eq("mid_rst_cnt0", acc_cnt0, 0);
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        tick();
        check_eq("after_rst_valid", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
